regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters: A (ALU/execute result) and B (load/memory result).
- Arbitrates with round-robin priority and registers the winning write onto the register-file write signals with one cycle of latency.
- Suppresses writes to $zero.
- Exposes an in-flight hazard query and a saturating conflict counter for performance visibility.

---
 rtl/mips_pkg.sv | 7 +
 rtl/rr_arbiter2.sv | 22 ++
 rtl/regfile_wb_arbiter.sv | 73 +++++++
 tb/tb_regfile_wb_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, the $zero index and requester-id encoding for writeback arbitration
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int ZERO_REG = 0;
  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_e;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: 2-way round-robin grant with a last-grant pointer
// Ports: clk/reset; req_a/req_b requests in; gnt_a/gnt_b one-hot-or-zero grants out.
// Grants are held low while reset is high; the pointer resets to REQ_B so A wins the first conflict.
module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);
  import mips_pkg::*;
  req_id_e last_q, last_d;
  always_comb begin
    gnt_a = !reset && req_a && (!req_b || last_q == REQ_B);
    gnt_b = !reset && req_b && (!req_a || last_q == REQ_A);
    last_d = gnt_a ? REQ_A : gnt_b ? REQ_B : last_q;
  end
  always_ff @(posedge clk) begin
    last_q <= reset ? REQ_B : last_d;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register-file write port between ALU (A) and load (B) writeback
// Ports: a_*/b_* valid-ready write requests; rf_* registered write port (1-cycle latency, $zero suppressed);
// q_addr/q_hit in-flight hazard query; conflict_cnt saturating count of cycles with both requesters valid.
module regfile_wb_arbiter #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] q_addr,
  output logic              q_hit,
  output logic [CNT_W-1:0]  conflict_cnt
);
  import mips_pkg::*;
  logic              gnt_a, gnt_b, grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req_a (a_valid),
    .req_b (b_valid),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );
  // A grant to $zero still completes the handshake and uses its turn; only the write enable is dropped.
  always_comb begin
    grant = gnt_a || gnt_b;
    sel_addr = gnt_a ? a_addr : b_addr;
    sel_data = gnt_a ? a_data : b_data;
    we_d = grant && sel_addr != ADDR_W'(ZERO_REG);
    waddr_d = grant ? sel_addr : waddr_q;
    wdata_d = grant ? sel_data : wdata_q;
    cnt_d = (a_valid && b_valid && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q <= '0;
    end else begin
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q <= cnt_d;
    end
  end
  // we_q is never set for index 0, so a query of $zero can never hit.
  assign q_hit = we_q && waddr_q == q_addr;
  assign a_ready = gnt_a;
  assign b_ready = gnt_b;
  assign rf_we = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed stimulus checked every cycle against a behavioural model plus literal pins
module tb_regfile_wb_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic a_valid = 1'b0, b_valid = 1'b0;
  logic [4:0] a_addr = '0, b_addr = '0, q_addr = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic a_ready, b_ready, rf_we, q_hit;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] conflict_cnt;
  int errors = 0, checks = 0;
  bit model_on = 1'b0;
  bit m_we, m_last_a;
  logic [4:0] m_waddr;
  logic [31:0] m_wdata;
  int m_cnt;
  logic [31:0] tb_rf [32];

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_addr(q_addr), .q_hit(q_hit), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_ga();
    return !reset && a_valid && (!b_valid || !m_last_a);
  endfunction

  function automatic bit exp_gb();
    return !reset && b_valid && (!a_valid || m_last_a);
  endfunction

  always @(posedge clk) begin
    if (rf_we) tb_rf[rf_waddr] <= rf_wdata;
  end

  always @(posedge clk) begin
    bit ga, gb;
    ga = exp_ga();
    gb = exp_gb();
    if (reset) begin
      m_we = 0; m_waddr = '0; m_wdata = '0; m_cnt = 0; m_last_a = 0;
    end else begin
      if (ga) begin
        m_we = a_addr != 0; m_waddr = a_addr; m_wdata = a_data; m_last_a = 1;
      end else if (gb) begin
        m_we = b_addr != 0; m_waddr = b_addr; m_wdata = b_data; m_last_a = 0;
      end else m_we = 0;
      if (a_valid && b_valid && m_cnt < 65535) m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("a_ready", a_ready, exp_ga());
      chk("b_ready", b_ready, exp_gb());
      chk("rf_we", rf_we, m_we);
      chk("rf_waddr", rf_waddr, m_waddr);
      chk("rf_wdata", rf_wdata, m_wdata);
      chk("conflict_cnt", conflict_cnt, m_cnt);
      chk("q_hit", q_hit, m_we && m_waddr == q_addr && q_addr != 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    a_valid = 1; a_addr = 5; a_data = 32'hDEADBEEF;
    cyc();
    model_on = 1;
    neg();
    chk("rst_a_ready", a_ready, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_cnt", conflict_cnt, 0);
    cyc(); reset = 0;
    neg(); chk("t1_a_ready", a_ready, 1);
    cyc(); a_valid = 0;
    neg();
    chk("t1_we", rf_we, 1);
    chk("t1_waddr", rf_waddr, 5);
    chk("t1_wdata", rf_wdata, 32'hDEADBEEF);
    cyc();
    neg(); chk("t1_we_off", rf_we, 0);

    cyc(); reset = 1;
    a_valid = 1; a_addr = 3; a_data = 32'h11;
    b_valid = 1; b_addr = 4; b_data = 32'h22;
    cyc(); reset = 0;
    for (int i = 0; i < 4; i++) begin
      neg();
      chk("t2_a_ready", a_ready, i % 2 == 0);
      chk("t2_b_ready", b_ready, i % 2 == 1);
      if (i > 0) chk("t2_waddr", rf_waddr, (i % 2) ? 3 : 4);
      cyc();
    end
    a_valid = 0; b_valid = 0;
    neg();
    chk("t2_waddr_last", rf_waddr, 4);
    chk("t2_cnt", conflict_cnt, 4);

    cyc();
    a_valid = 1; a_addr = 7; a_data = 32'h1;
    b_valid = 1; b_addr = 7; b_data = 32'h2;
    neg(); chk("t3_a_first", a_ready, 1);
    cyc(); a_valid = 0;
    neg();
    chk("t3_we1", rf_we, 1);
    chk("t3_wdata1", rf_wdata, 32'h1);
    chk("t3_b_ready", b_ready, 1);
    cyc(); b_valid = 0;
    neg();
    chk("t3_we2", rf_we, 1);
    chk("t3_wdata2", rf_wdata, 32'h2);
    cyc();
    neg(); chk("t3_readback", tb_rf[7], 32'h2);

    b_valid = 1; b_addr = 0; b_data = 32'hFFFF; q_addr = 0;
    neg(); chk("t4_b_ready", b_ready, 1);
    cyc(); b_valid = 0;
    neg();
    chk("t4_we", rf_we, 0);
    chk("t4_qhit", q_hit, 0);

    cyc();
    a_valid = 1; a_addr = 1; a_data = 32'hAA;
    b_valid = 1; b_addr = 2; b_data = 32'hBB; q_addr = 1;
    cyc(); cyc(); reset = 1;
    neg();
    chk("t5_a_ready_rst", a_ready, 0);
    chk("t5_b_ready_rst", b_ready, 0);
    cyc(); reset = 0;
    neg();
    chk("t5_we", rf_we, 0);
    chk("t5_cnt", conflict_cnt, 0);
    chk("t5_a_first", a_ready, 1);
    cyc(); a_valid = 0; b_valid = 0;

    cyc(); reset = 1;
    cyc(); reset = 0;
    a_valid = 1; a_addr = 9; a_data = 32'h99;
    b_valid = 1; b_addr = 10; b_data = 32'hAB; q_addr = 9;
    repeat (16'hFFFE) cyc();
    neg(); chk("t6_cnt_fffe", conflict_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      cyc();
      neg(); chk("t6_cnt_sat", conflict_cnt, 16'hFFFF);
    end
    cyc(); a_valid = 0; b_valid = 0;
    cyc(); a_valid = 1;
    cyc(); a_valid = 0;
    neg(); chk("t6_qhit", q_hit, 1);
    q_addr = 10;
    #1 chk("t6_qhit_other", q_hit, 0);
    cyc();
    neg(); chk("t6_qhit_idle", q_hit, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
